crush_lvds_rx_align: RTL and testbench



---
 rtl/crush_lvds_rx_align.sv | 192 +++++++++++++++++++
 tb/tb_crush_lvds_rx_align.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crush_lvds_rx_align.sv
// -----------------------------------------------------------------------------
// crush_lvds_rx_align
//
// Receive-side word aligner for the CRUSH 14-bit DDR sample link. It sits
// behind the IDDR capture primitives in the forwarded-clock domain. Each
// cycle it pairs the rising-edge and falling-edge half-words into I/Q
// samples. The correct pairing phase is recovered from a continuous
// training pattern. Once locked, the block outputs samples with a valid
// strobe. While training is asserted it counts pattern mismatches.
//
// Ports:
//   clk_i            capture-domain clock (rising edge)
//   rst_i            asynchronous active-high reset
//   rx_rise_i        half-word captured on the rising forwarded-clock edge
//   rx_fall_i        half-word captured on the falling edge, same cycle
//   train_en_i       transmitter is sending the training pattern
//   clear_err_i      synchronous clear of err_cnt_o (wins over an increment)
//   sample_i_o       recovered I sample
//   sample_q_o       recovered Q sample
//   sample_valid_o   one-cycle qualifier per I/Q pair (locked, not training)
//   locked_o         high in the LOCKED state
//   swapped_o        pairing phase: 0 = {rise,fall}, 1 = {previous fall,rise}
//   err_cnt_o        saturating count of training mismatches while locked
// -----------------------------------------------------------------------------
module crush_lvds_rx_align #(
    parameter int               WIDTH    = 14,
    parameter logic [WIDTH-1:0] TRAIN_I  = 14'h1A5C,
    parameter logic [WIDTH-1:0] TRAIN_Q  = 14'h25A3,
    parameter int               LOCK_CNT = 16,
    parameter int               LOSS_CNT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] rx_rise_i,
    input  logic [WIDTH-1:0] rx_fall_i,
    input  logic             train_en_i,
    input  logic             clear_err_i,
    output logic [WIDTH-1:0] sample_i_o,
    output logic [WIDTH-1:0] sample_q_o,
    output logic             sample_valid_o,
    output logic             locked_o,
    output logic             swapped_o,
    output logic [15:0]      err_cnt_o
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0] LOCK_CNT_W = LOCK_CNT[7:0];
    localparam logic [3:0] LOSS_CNT_W = LOSS_CNT[3:0];

    logic [1:0]       state_q,    state_d;
    logic [7:0]       cnt_q,      cnt_d;
    logic [3:0]       loss_q,     loss_d;
    logic             phase_q,    phase_d;
    logic [WIDTH-1:0] fall_prev_q;
    logic [WIDTH-1:0] sample_i_q, sample_i_d;
    logic [WIDTH-1:0] sample_q_q, sample_q_d;
    logic             valid_q,    valid_d;
    logic             locked_q,   locked_d;
    logic [15:0]      err_cnt_q,  err_cnt_d;

    logic             p0_match_s;
    logic             p1_match_s;
    logic             sel_match_s;
    logic [WIDTH-1:0] sel_i_s;
    logic [WIDTH-1:0] sel_q_s;

    // Candidate pairings and the pair chosen by the current phase.
    always_comb begin
        p0_match_s  = (rx_rise_i == TRAIN_I) && (rx_fall_i == TRAIN_Q);
        p1_match_s  = (fall_prev_q == TRAIN_I) && (rx_rise_i == TRAIN_Q);
        sel_i_s     = phase_q ? fall_prev_q : rx_rise_i;
        sel_q_s     = phase_q ? rx_rise_i   : rx_fall_i;
        sel_match_s = (sel_i_s == TRAIN_I) && (sel_q_s == TRAIN_Q);
    end

    // Alignment state machine, error accounting and output next-state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_d     = loss_q;
        phase_d    = phase_q;
        sample_i_d = sample_i_q;
        sample_q_d = sample_q_q;
        valid_d    = 1'b0;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_SEARCH: begin
                // P0 is checked first, so it wins when both pairings match.
                if (train_en_i && p0_match_s) begin
                    phase_d = 1'b0;
                    cnt_d   = 8'd1;
                    state_d = ST_VERIFY;
                end else if (train_en_i && p1_match_s) begin
                    phase_d = 1'b1;
                    cnt_d   = 8'd1;
                    state_d = ST_VERIFY;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_VERIFY: begin
                if (train_en_i && sel_match_s) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == LOCK_CNT_W) begin
                        state_d = ST_LOCKED;
                        loss_d  = 4'd0;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end else begin
                    state_d = ST_SEARCH;
                    cnt_d   = 8'd0;
                end
            end
            ST_LOCKED: begin
                // Samples keep updating during training for debug visibility;
                // only the qualifier is suppressed.
                sample_i_d = sel_i_s;
                sample_q_d = sel_q_s;
                valid_d    = ~train_en_i;
                if (train_en_i) begin
                    if (!sel_match_s) begin
                        err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : (err_cnt_q + 16'd1);
                        if ((loss_q + 4'd1) == LOSS_CNT_W) begin
                            state_d = ST_SEARCH;
                            cnt_d   = 8'd0;
                            loss_d  = 4'd0;
                        end else begin
                            loss_d  = loss_q + 4'd1;
                        end
                    end else begin
                        loss_d = 4'd0;
                    end
                end else begin
                    loss_d = loss_q;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                cnt_d   = 8'd0;
                loss_d  = 4'd0;
            end
        endcase

        if (clear_err_i) begin
            err_cnt_d = 16'd0;
        end else begin
            err_cnt_d = err_cnt_d;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers; reset drops lock without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_SEARCH;
            cnt_q       <= 8'd0;
            loss_q      <= 4'd0;
            phase_q     <= 1'b0;
            fall_prev_q <= '0;
            sample_i_q  <= '0;
            sample_q_q  <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            phase_q     <= phase_d;
            fall_prev_q <= rx_fall_i;
            sample_i_q  <= sample_i_d;
            sample_q_q  <= sample_q_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign sample_i_o     = sample_i_q;
    assign sample_q_o     = sample_q_q;
    assign sample_valid_o = valid_q;
    assign locked_o       = locked_q;
    assign swapped_o      = phase_q;
    assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_crush_lvds_rx_align.sv
// -----------------------------------------------------------------------------
// tb_crush_lvds_rx_align
//
// Two aligner instances run side by side: u_dut (LOSS_CNT=4) and u_sat
// (LOSS_CNT=15, used for err_cnt saturation). A behavioural reference
// model predicts every output of both instances every cycle. Directed
// checks cover the lock, loss, swap, verify-abort and reset scenarios.
// -----------------------------------------------------------------------------
module tb_crush_lvds_rx_align;

    localparam logic [13:0] TI   = 14'h1A5C;
    localparam logic [13:0] TQ   = 14'h25A3;
    localparam int          LOCK = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] rise  [2];
    logic [13:0] fall  [2];
    logic        train [2];
    logic        clr   [2];
    logic [13:0] si_o  [2];
    logic [13:0] sq_o  [2];
    logic        sv_o  [2];
    logic        lk_o  [2];
    logic        sw_o  [2];
    logic [15:0] err_o [2];

    // Reference model state: mode 0=search 1=verify 2=locked
    int          m_mode  [2];
    bit          m_phase [2];
    int          m_cnt   [2];
    int          m_loss  [2];
    int          m_err   [2];
    logic [13:0] m_pf    [2];
    logic [13:0] m_si    [2];
    logic [13:0] m_sq    [2];
    bit          m_sv    [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crush_lvds_rx_align #(.LOSS_CNT(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .rx_rise_i(rise[0]), .rx_fall_i(fall[0]),
        .train_en_i(train[0]), .clear_err_i(clr[0]), .sample_i_o(si_o[0]),
        .sample_q_o(sq_o[0]), .sample_valid_o(sv_o[0]), .locked_o(lk_o[0]),
        .swapped_o(sw_o[0]), .err_cnt_o(err_o[0])
    );

    crush_lvds_rx_align #(.LOSS_CNT(15)) u_sat (
        .clk_i(clk), .rst_i(rst), .rx_rise_i(rise[1]), .rx_fall_i(fall[1]),
        .train_en_i(train[1]), .clear_err_i(clr[1]), .sample_i_o(si_o[1]),
        .sample_q_o(sq_o[1]), .sample_valid_o(sv_o[1]), .locked_o(lk_o[1]),
        .swapped_o(sw_o[1]), .err_cnt_o(err_o[1])
    );

    function automatic int lim_of(input int k);
        return (k == 0) ? 4 : 15;
    endfunction

    function automatic logic [13:0] rmask();
        logic [13:0] m;
        m = 14'($urandom_range(1, 16383));
        return m;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_phase[k] = 1'b0; m_cnt[k] = 0; m_loss[k] = 0; m_err[k] = 0;
            m_pf[k] = '0; m_si[k] = '0; m_sq[k] = '0; m_sv[k] = 1'b0;
        end
    endtask

    // One clock edge of the link rules, applied to the inputs held during it.
    task automatic model_step(input int k);
        logic        p0, p1, sel;
        logic [13:0] pi, pq;
        p0  = (rise[k] == TI) && (fall[k] == TQ);
        p1  = (m_pf[k] == TI) && (rise[k] == TQ);
        pi  = m_phase[k] ? m_pf[k] : rise[k];
        pq  = m_phase[k] ? rise[k] : fall[k];
        sel = (pi == TI) && (pq == TQ);
        m_sv[k] = 1'b0;
        if (m_mode[k] == 0) begin
            if (train[k] && p0) begin
                m_phase[k] = 1'b0; m_cnt[k] = 1; m_mode[k] = 1;
            end else if (train[k] && p1) begin
                m_phase[k] = 1'b1; m_cnt[k] = 1; m_mode[k] = 1;
            end
        end else if (m_mode[k] == 1) begin
            if (train[k] && sel) begin
                m_cnt[k]++;
                if (m_cnt[k] == LOCK) begin
                    m_mode[k] = 2; m_loss[k] = 0;
                end
            end else begin
                m_mode[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            m_si[k] = pi;
            m_sq[k] = pq;
            m_sv[k] = !train[k];
            if (train[k]) begin
                if (!sel) begin
                    if (m_err[k] < 65535) m_err[k]++;
                    m_loss[k]++;
                    if (m_loss[k] == lim_of(k)) begin
                        m_mode[k] = 0; m_cnt[k] = 0; m_loss[k] = 0;
                    end
                end else begin
                    m_loss[k] = 0;
                end
            end
        end
        if (clr[k]) m_err[k] = 0;
        m_pf[k] = fall[k];
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("sample_i", k, 32'(si_o[k]), 32'(m_si[k]));
            chk("sample_q", k, 32'(sq_o[k]), 32'(m_sq[k]));
            chk("sample_valid", k, 32'(sv_o[k]), 32'(m_sv[k]));
            chk("locked", k, 32'(lk_o[k]), 32'(m_mode[k] == 2));
            chk("swapped", k, 32'(sw_o[k]), 32'(m_phase[k]));
            chk("err_cnt", k, 32'(err_o[k]), 32'(m_err[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic set_in(input int k, input logic [13:0] r, input logic [13:0] f, input logic t, input logic c);
        rise[k] = r; fall[k] = f; train[k] = t; clr[k] = c;
    endtask

    task automatic set_both(input logic [13:0] r, input logic [13:0] f, input logic t, input logic c);
        set_in(0, r, f, t, c);
        set_in(1, r, f, t, c);
    endtask

    // Training pair in the given transmit phase, optionally corrupted on rise.
    task automatic train_pat(input bit ph, input bit corrupt);
        logic [13:0] r, f;
        r = ph ? TQ : TI;
        f = ph ? TI : TQ;
        if (corrupt) r = r ^ rmask();
        set_both(r, f, 1'b1, 1'b0);
    endtask

    initial begin
        logic [13:0] pf_exp, r, f;
        bit          tx_ph, t_on;

        // ---- reset state ----
        set_both(14'h0, 14'h0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_locked", 0, 32'(lk_o[0]), 32'd0);
        chk("rst_valid", 0, 32'(sv_o[0]), 32'd0);
        chk("rst_err", 0, 32'(err_o[0]), 32'd0);
        chk("rst_sample_i", 0, 32'(si_o[0]), 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // ---- P0 aligned training: lock after exactly 16 pairs ----
        for (int i = 0; i < LOCK - 1; i++) begin
            train_pat(1'b0, 1'b0);
            cycle();
        end
        chk("p0_not_yet_locked", 0, 32'(lk_o[0]), 32'd0);
        train_pat(1'b0, 1'b0);
        cycle();
        chk("p0_locked", 0, 32'(lk_o[0]), 32'd1);
        chk("p0_swapped", 0, 32'(sw_o[0]), 32'd0);
        chk("p0_err", 0, 32'(err_o[0]), 32'd0);
        chk("p0_valid_training", 0, 32'(sv_o[0]), 32'd0);

        // ---- isolated errors, then loss of lock ----
        for (int i = 0; i < 3; i++) begin
            train_pat(1'b0, 1'b1);
            cycle();
            train_pat(1'b0, 1'b0);
            cycle();
            cycle();
        end
        chk("isolated_err", 0, 32'(err_o[0]), 32'd3);
        chk("isolated_locked", 0, 32'(lk_o[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            train_pat(1'b0, 1'b1);
            cycle();
            if (i == 2) chk("loss_third_locked", 0, 32'(lk_o[0]), 32'd1);
        end
        chk("loss_unlocked", 0, 32'(lk_o[0]), 32'd0);
        chk("loss_err", 0, 32'(err_o[0]), 32'd7);

        // ---- P1 training (offset by one half) ----
        // First cycle cannot match: the previous fall still holds TQ.
        for (int i = 0; i < LOCK; i++) begin
            train_pat(1'b1, 1'b0);
            cycle();
        end
        chk("p1_not_yet_locked", 0, 32'(lk_o[0]), 32'd0);
        train_pat(1'b1, 1'b0);
        cycle();
        chk("p1_locked", 0, 32'(lk_o[0]), 32'd1);
        chk("p1_swapped", 0, 32'(sw_o[0]), 32'd1);
        pf_exp = TI;
        for (int i = 0; i < 20; i++) begin
            r = 14'($urandom);
            f = 14'($urandom);
            set_both(r, f, 1'b0, 1'b0);
            cycle();
            chk("p1_data_i", 0, 32'(si_o[0]), 32'(pf_exp));
            chk("p1_data_q", 0, 32'(sq_o[0]), 32'(r));
            chk("p1_data_valid", 0, 32'(sv_o[0]), 32'd1);
            pf_exp = f;
        end

        // ---- drop lock, then abort VERIFY on the 10th pair ----
        for (int i = 0; i < 4; i++) begin
            train_pat(1'b1, 1'b1);
            cycle();
        end
        set_both(14'($urandom), 14'($urandom), 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 9; i++) begin
            train_pat(1'b0, 1'b0);
            cycle();
        end
        train_pat(1'b0, 1'b1);
        cycle();
        chk("verify_abort_locked", 0, 32'(lk_o[0]), 32'd0);
        for (int i = 0; i < LOCK - 1; i++) begin
            train_pat(1'b0, 1'b0);
            cycle();
        end
        chk("relock_not_yet", 0, 32'(lk_o[0]), 32'd0);
        train_pat(1'b0, 1'b0);
        cycle();
        chk("relock_locked", 0, 32'(lk_o[0]), 32'd1);

        // ---- randomized traffic against the model ----
        tx_ph = 1'b0;
        t_on  = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) tx_ph = ~tx_ph;
            if ($urandom_range(0, 99) == 0) t_on = ~t_on;
            if (t_on) begin
                r = tx_ph ? TQ : TI;
                f = tx_ph ? TI : TQ;
                if ($urandom_range(0, 31) == 0) r = r ^ rmask();
            end else begin
                r = 14'($urandom);
                f = 14'($urandom);
            end
            set_both(r, f, t_on, ($urandom_range(0, 63) == 0));
            cycle();
        end

        // ---- asynchronous reset mid-lock ----
        for (int i = 0; i < 24; i++) begin
            train_pat(1'b0, 1'b0);
            cycle();
        end
        chk("pre_rst_locked", 0, 32'(lk_o[0]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            train_pat(1'b0, 1'b1);
            cycle();
            train_pat(1'b0, 1'b0);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            set_both(14'($urandom), 14'($urandom), 1'b0, 1'b0);
            cycle();
        end
        chk("pre_rst_valid", 0, 32'(sv_o[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_locked", 0, 32'(lk_o[0]), 32'd0);
        chk("async_rst_valid", 0, 32'(sv_o[0]), 32'd0);
        chk("async_rst_err", 0, 32'(err_o[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < LOCK - 1; i++) begin
            train_pat(1'b0, 1'b0);
            cycle();
        end
        chk("post_rst_not_yet", 0, 32'(lk_o[0]), 32'd0);
        train_pat(1'b0, 1'b0);
        cycle();
        chk("post_rst_locked", 0, 32'(lk_o[0]), 32'd1);

        // ---- err_cnt saturation on the LOSS_CNT=15 instance ----
        chk("sat_start_locked", 1, 32'(lk_o[1]), 32'd1);
        for (int n = 0; n < 4715; n++) begin
            for (int j = 0; j < 15; j++) begin
                set_in(0, 14'($urandom), 14'($urandom), 1'b0, 1'b0);
                set_in(1, (j < 14) ? (TI ^ rmask()) : TI, TQ, 1'b1, 1'b0);
                cycle();
            end
        end
        chk("sat_err", 1, 32'(err_o[1]), 32'h0000FFFF);
        chk("sat_locked", 1, 32'(lk_o[1]), 32'd1);
        set_in(1, TI ^ rmask(), TQ, 1'b1, 1'b1);
        cycle();
        chk("clear_beats_inc", 1, 32'(err_o[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
